tl_dmi_responder: RTL and testbench
===================================

TL_DMI_RESPONDER -- requirements
Module: tl_dmi_responder

Interface
REQ-001 Parameter SRC_W, default 2, source ID width echoed from A to D.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 a_valid  input  1  A-channel request valid.
REQ-005 a_ready  output  1  A-channel request accepted when high with a_valid.
REQ-006 a_opcode  input  3  0 PutFullData, 1 PutPartialData, 4 Get.
REQ-007 a_size  input  3  log2 bytes; only 2 legal.
REQ-008 a_source  input  SRC_W  requester ID.
REQ-009 a_address  input  9  byte address; bits[1:0] ignored.
REQ-010 a_mask  input  4  byte-lane write enables.
REQ-011 a_data  input  32  write data.
REQ-012 d_valid  output  1  D-channel response valid.
REQ-013 d_ready  input  1  response consumed when high with d_valid.
REQ-014 d_opcode  output  3  0 AccessAck, 1 AccessAckData.
REQ-015 d_size  output  3  echo of accepted a_size.
REQ-016 d_source  output  SRC_W  echo of accepted a_source.
REQ-017 d_denied  output  1  request rejected; no state change.
REQ-018 d_data  output  32  read data; 0 for AccessAck and denied responses.

Function
REQ-019 A request is accepted (A-fire) on a cycle with a_valid and a_ready both high.
REQ-020 Map: DATA[0..15] at 0x000-0x03C (index a_address[5:2]); CTRL at 0x040; every other address is unmapped.
REQ-021 CTRL[15:0] is read/write; CTRL[31:16] is read-only PUTCNT.
REQ-022 State machine has two states: IDLE (d_valid=0, a_ready=1) and RESP (d_valid=1).
REQ-023 IDLE -> RESP on A-fire; RESP -> IDLE on D-fire without A-fire; RESP stays RESP on simultaneous D-fire and A-fire, loading the new response.
REQ-024 In RESP, a_ready equals d_ready, so back-to-back requests sustain one transaction per cycle.
REQ-025 Latency: d_valid rises the cycle after A-fire; D fields stay stable while d_valid && !d_ready.
REQ-026 Denied when the opcode is not in {0,1,4}, a_size != 2, or the address is unmapped.
REQ-027 Denied requests get d_opcode=1 for Get and 0 otherwise, d_denied=1, d_data=0, and cause no register or PUTCNT change.
REQ-028 A legal Put updates the byte lanes of the target register where a_mask is set, at the A-fire edge; PutFullData uses a_mask as given.
REQ-029 A Put to CTRL writes only bits[15:0]; mask bits 2 and 3 are ignored for CTRL.
REQ-030 A legal Put (DATA or CTRL) increments PUTCNT by 1, modulo 65536 (0xFFFF wraps to 0x0000).
REQ-031 A legal Get captures register contents at the A-fire edge into d_data; a Put accepted on the immediately preceding cycle is visible.
REQ-032 A Get of CTRL returns {PUTCNT, CTRL[15:0]}, with PUTCNT as it stood before the current cycle.

Reset
REQ-033 While reset_n is low: d_valid=0, a_ready=1, d_opcode=0, d_size=0, d_source=0, d_denied=0, d_data=0, all DATA=0, CTRL=0, PUTCNT=0, FSM=IDLE.
REQ-034 Reset asserted mid-transaction discards any pending response; no D-fire occurs for it.
REQ-035 The first request can be accepted on the first rising clock edge after reset_n deasserts.

Structure
REQ-036 Shared package holds the opcode constants (PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACK=0, ACK_DATA=1), CTRL_ADDR=0x040, DATA_WORDS=16 and the FSM state enum.
REQ-037 One sub-module, tl_dmi_regbank: holds DATA/CTRL/PUTCNT and provides masked write plus combinational read; the FSM and D-channel registers stay in the top level.

Verification
REQ-038 Put 0x000 data 0xDEADBEEF mask 0xF, src 1, then Get 0x000 -> AccessAck src 1, then AccessAckData data 0xDEADBEEF, d_denied=0.
REQ-039 PutPartial 0x004 data 0x11223344 mask 0x5 over 0xFFFFFFFF -> Get 0x004 returns 0xFF22FF44.
REQ-040 Get 0x080, opcode 2, and Put with a_size 1 -> each d_denied=1, d_data=0; following Get of 0x040 shows PUTCNT unchanged.
REQ-041 d_ready held low 5 cycles with a_valid high -> D fields stable and a_ready=0 throughout; after d_ready rises, one response per cycle.
REQ-042 65536 legal Puts to 0x040 data 0x0000ABCD -> Get 0x040 returns 0x0000ABCD (PUTCNT wrapped).
REQ-043 reset_n pulsed low while d_valid=1 -> d_valid drops immediately, and all registers read back 0 afterwards.

Source files
------------

// File: rtl/tl_dmi_responder_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the TileLink-UL DMI responder.
package tl_dmi_responder_pkg;

  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned WADDR_W    = 7;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MASK_W     = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned DATA_WORDS = 16;
  localparam int unsigned IDX_W      = 4;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;
  localparam logic [2:0] LEGAL_SIZE  = 3'd2;

  localparam logic [ADDR_W-1:0] CTRL_ADDR = 9'h040;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Replace the byte lanes of cur selected by mask with the matching lanes of wdata.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int b = 0; b < int'(MASK_W); b++) begin
      if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tl_dmi_regbank.sv
// DATA[0..15], CTRL and PUTCNT storage: masked write at the clock edge, combinational read.
module tl_dmi_regbank
  import tl_dmi_responder_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WADDR_W-1:0] waddr,
  input  logic               wr_en,
  input  logic [MASK_W-1:0]  wr_mask,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               hit,
  output logic [DATA_W-1:0]  rd_data
);

  logic [DATA_W-1:0] data_q [DATA_WORDS];
  logic [CNT_W-1:0]  ctrl_q;
  logic [CNT_W-1:0]  putcnt_q;
  logic              is_data;
  logic              is_ctrl;
  logic [IDX_W-1:0]  idx;

  assign idx     = waddr[IDX_W-1:0];
  assign is_data = (waddr[WADDR_W-1:IDX_W] == '0);
  assign is_ctrl = (waddr == CTRL_ADDR[ADDR_W-1:2]);
  assign hit     = is_data || is_ctrl;
  assign rd_data = is_ctrl ? {putcnt_q, ctrl_q} : (is_data ? data_q[idx] : '0);

  // CTRL only has its low half writable, so upper mask lanes are dropped there.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DATA_WORDS); i++) data_q[i] <= '0;
      ctrl_q   <= '0;
      putcnt_q <= '0;
    end else if (wr_en && hit) begin
      putcnt_q <= putcnt_q + CNT_W'(1);
      if (is_ctrl) begin
        ctrl_q <= CNT_W'(merge_bytes({CNT_W'(0), ctrl_q}, wr_data, {2'b00, wr_mask[1:0]}));
      end else begin
        data_q[idx] <= merge_bytes(data_q[idx], wr_data, wr_mask);
      end
    end
  end

endmodule

// File: rtl/tl_dmi_responder.sv
// TileLink-UL slave for a small DMI register window: one outstanding response, full-throughput pipelining.
module tl_dmi_responder
  import tl_dmi_responder_pkg::*;
#(
  parameter int unsigned SRC_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [MASK_W-1:0] a_mask,
  input  logic [DATA_W-1:0] a_data,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [2:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_denied,
  output logic [DATA_W-1:0] d_data
);

  state_e            state;
  logic              a_fire;
  logic              d_fire;
  logic              is_get;
  logic              is_put;
  logic              hit;
  logic              legal;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^a_address[1:0];

  // A new request may replace the held response in the same cycle it is consumed.
  assign a_ready = (state == ST_IDLE) || d_ready;
  assign d_valid = (state == ST_RESP);
  assign a_fire  = a_valid && a_ready;
  assign d_fire  = d_valid && d_ready;

  assign is_get = (a_opcode == GET);
  assign is_put = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
  assign legal  = (is_get || is_put) && (a_size == LEGAL_SIZE) && hit;
  assign wr_en  = a_fire && legal && is_put;

  tl_dmi_regbank u_regbank (
    .clock   (clock),
    .reset_n (reset_n),
    .waddr   (a_address[ADDR_W-1:2]),
    .wr_en   (wr_en),
    .wr_mask (a_mask),
    .wr_data (a_data),
    .hit     (hit),
    .rd_data (rd_data)
  );

  // FSM and D-channel response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      d_opcode <= ACK;
      d_size   <= '0;
      d_source <= '0;
      d_denied <= 1'b0;
      d_data   <= '0;
    end else if (a_fire) begin
      state    <= ST_RESP;
      d_opcode <= is_get ? ACK_DATA : ACK;
      d_size   <= a_size;
      d_source <= a_source;
      d_denied <= !legal;
      d_data   <= (legal && is_get) ? rd_data : '0;
    end else if (d_fire) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_tl_dmi_responder.sv
// Scoreboarded bench for tl_dmi_responder: expected D responses come from a behavioural register model.
`timescale 1ns/1ps
module tb_tl_dmi_responder;

  localparam int unsigned SRC_W = 2;

  typedef struct packed {
    logic [2:0]       op;
    logic [2:0]       size;
    logic [SRC_W-1:0] src;
    logic [8:0]       addr;
    logic [3:0]       mask;
    logic [31:0]      data;
  } req_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [2:0]       size;
    logic [SRC_W-1:0] src;
    logic             denied;
    logic [31:0]      data;
  } resp_t;

  logic             clock;
  logic             reset_n;
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_opcode;
  logic [2:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [8:0]       a_address;
  logic [3:0]       a_mask;
  logic [31:0]      a_data;
  logic             d_valid;
  logic             d_ready;
  logic [2:0]       d_opcode;
  logic [2:0]       d_size;
  logic [SRC_W-1:0] d_source;
  logic             d_denied;
  logic [31:0]      d_data;

  resp_t       sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] m_data [16];
  logic [15:0] m_ctrl;
  logic [15:0] m_putcnt;

  tl_dmi_responder #(.SRC_W(SRC_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_denied  (d_denied),
    .d_data    (d_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic req_t mk(input logic [2:0] op, input logic [2:0] size, input logic [SRC_W-1:0] src,
                              input logic [8:0] addr, input logic [3:0] mask, input logic [31:0] data);
    req_t r;
    r.op = op; r.size = size; r.src = src; r.addr = addr; r.mask = mask; r.data = data;
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_data[i] = '0;
    m_ctrl   = '0;
    m_putcnt = '0;
  endfunction

  // Reference behaviour of one accepted request; updates the model state.
  function automatic resp_t model(input req_t r);
    resp_t e;
    logic  get, put, in_data, in_ctrl, legal;
    get     = (r.op == 3'd4);
    put     = (r.op == 3'd0) || (r.op == 3'd1);
    in_data = (r.addr < 9'h040);
    in_ctrl = (r.addr >= 9'h040) && (r.addr <= 9'h043);
    legal   = (get || put) && (r.size == 3'd2) && (in_data || in_ctrl);
    e.op     = get ? 3'd1 : 3'd0;
    e.size   = r.size;
    e.src    = r.src;
    e.denied = ~legal;
    e.data   = '0;
    if (legal && get) e.data = in_data ? m_data[r.addr[5:2]] : {m_putcnt, m_ctrl};
    if (legal && put) begin
      m_putcnt = m_putcnt + 16'd1;
      for (int b = 0; b < 4; b++) begin
        if (r.mask[b]) begin
          if (in_data) m_data[r.addr[5:2]][8*b +: 8] = r.data[8*b +: 8];
          else if (b < 2) m_ctrl[8*b +: 8] = r.data[8*b +: 8];
        end
      end
    end
    return e;
  endfunction

  task automatic drive_req(input req_t r);
    a_valid = 1'b1; a_opcode = r.op; a_size = r.size; a_source = r.src;
    a_address = r.addr; a_mask = r.mask; a_data = r.data;
  endtask

  task automatic drive_idle();
    a_valid = 1'b0; a_opcode = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0;
  endtask

  function automatic resp_t observe();
    return {d_opcode, d_size, d_source, d_denied, d_data};
  endfunction

  // One serial transaction: push expected on acceptance, return the D fields seen.
  task automatic xact(input req_t r, output resp_t got, output bit to, output int lat);
    got = '0; to = 1'b1; lat = 0;
    @(posedge clock); #1;
    drive_req(r);
    d_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (a_ready) begin sb.push_back(model(r)); to = 1'b0; break; end
    end
    @(posedge clock); #1;
    drive_idle();
    if (!to) begin
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        lat = i + 1;
        if (d_valid) begin got = observe(); to = 1'b0; break; end
      end
    end
  endtask

  task automatic test_reset();
    resp_t got, exp;
    req_t  r;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (d_valid !== 1'b0 || a_ready !== 1'b1 || observe() !== '0) begin
      n_fails++;
      $display("FAIL reset_state: d_valid=%b a_ready=%b d=%h, required 0 1 0", d_valid, a_ready, observe());
    end
    r = mk(3'd4, 3'd2, 2'd3, 9'h000, 4'h0, 32'h0);
    reset_n = 1'b1;
    d_ready = 1'b1;
    drive_req(r);
    sb.push_back(model(r));
    @(negedge clock);
    n_checks++;
    if (d_valid !== 1'b1 || sb.size() == 0) begin
      n_fails++;
      $display("FAIL first_after_reset: d_valid=%b, required 1", d_valid);
      sb.delete();
    end else begin
      exp = sb.pop_front();
      got = observe();
      if (got !== exp) begin
        n_fails++;
        $display("FAIL first_after_reset: got %h required %h", got, exp);
      end
    end
    drive_idle();
  endtask

  task automatic test_put_get();
    req_t  rq [2];
    resp_t got, exp;
    bit    to;
    int    lat;
    rq[0] = mk(3'd0, 3'd2, 2'd1, 9'h000, 4'hF, 32'hDEADBEEF);
    rq[1] = mk(3'd4, 3'd2, 2'd1, 9'h000, 4'h0, 32'h0);
    foreach (rq[i]) begin
      xact(rq[i], got, to, lat);
      n_checks++;
      if (to || sb.size() == 0) begin
        n_fails++; $display("FAIL put_get[%0d]: no response within bound", i); sb.delete();
      end else begin
        exp = sb.pop_front();
        if (got !== exp || lat != 1) begin
          n_fails++; $display("FAIL put_get[%0d]: got %h lat %0d, required %h lat 1", i, got, lat, exp);
        end
      end
    end
    n_checks++;
    if (got.data !== 32'hDEADBEEF || got.op !== 3'd1 || got.denied !== 1'b0 || got.src !== 2'd1) begin
      n_fails++; $display("FAIL put_get_readback: got %h, required data DEADBEEF op 1 src 1", got);
    end
  endtask

  task automatic test_partial();
    req_t  rq [5];
    resp_t gots [5];
    resp_t got, exp;
    bit    to;
    int    lat;
    rq[0] = mk(3'd0, 3'd2, 2'd2, 9'h004, 4'hF, 32'hFFFFFFFF);
    rq[1] = mk(3'd1, 3'd2, 2'd3, 9'h004, 4'h5, 32'h11223344);
    rq[2] = mk(3'd4, 3'd2, 2'd0, 9'h006, 4'h0, 32'h0);
    rq[3] = mk(3'd1, 3'd2, 2'd1, 9'h040, 4'hF, 32'hAAAA5555);
    rq[4] = mk(3'd4, 3'd2, 2'd2, 9'h040, 4'h0, 32'h0);
    foreach (rq[i]) begin
      xact(rq[i], got, to, lat);
      gots[i] = got;
      n_checks++;
      if (to || sb.size() == 0) begin
        n_fails++; $display("FAIL partial[%0d]: no response within bound", i); sb.delete();
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fails++; $display("FAIL partial[%0d]: got %h required %h", i, got, exp);
        end
      end
    end
    n_checks++;
    if (gots[2].data !== 32'hFF22FF44) begin
      n_fails++; $display("FAIL partial_merge: got %h required FF22FF44", gots[2].data);
    end
  endtask

  task automatic test_denied();
    req_t        rq [6];
    resp_t       gots [6];
    resp_t       got, exp;
    bit          to;
    int          lat;
    logic [15:0] cnt0;
    cnt0 = m_putcnt;
    rq[0] = mk(3'd4, 3'd2, 2'd1, 9'h080, 4'h0, 32'h0);
    rq[1] = mk(3'd2, 3'd2, 2'd2, 9'h000, 4'hF, 32'h12345678);
    rq[2] = mk(3'd0, 3'd1, 2'd3, 9'h040, 4'hF, 32'h0000FFFF);
    rq[3] = mk(3'd0, 3'd2, 2'd0, 9'h044, 4'hF, 32'h55555555);
    rq[4] = mk(3'd4, 3'd3, 2'd1, 9'h000, 4'h0, 32'h0);
    rq[5] = mk(3'd4, 3'd2, 2'd2, 9'h040, 4'h0, 32'h0);
    foreach (rq[i]) begin
      xact(rq[i], got, to, lat);
      gots[i] = got;
      n_checks++;
      if (to || sb.size() == 0) begin
        n_fails++; $display("FAIL denied[%0d]: no response within bound", i); sb.delete();
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fails++; $display("FAIL denied[%0d]: got %h required %h", i, got, exp);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (gots[i].denied !== 1'b1 || gots[i].data !== 32'h0) begin
        n_fails++; $display("FAIL denied_flag[%0d]: denied=%b data=%h, required 1 and 0", i, gots[i].denied, gots[i].data);
      end
    end
    n_checks++;
    if (gots[5].data[31:16] !== cnt0 || gots[5].denied !== 1'b0) begin
      n_fails++; $display("FAIL denied_putcnt: got %h required %h", gots[5].data[31:16], cnt0);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    req_t  rq [N];
    resp_t cur, held, exp;
    int    idx, done, cyc;
    bit    fire;
    rq[0] = mk(3'd0, 3'd2, 2'd0, 9'h020, 4'hF, 32'hCAFEF00D);
    rq[1] = mk(3'd4, 3'd2, 2'd1, 9'h020, 4'h0, 32'h0);
    rq[2] = mk(3'd1, 3'd2, 2'd2, 9'h020, 4'h2, 32'h0000AB00);
    rq[3] = mk(3'd4, 3'd2, 2'd3, 9'h020, 4'h0, 32'h0);
    rq[4] = mk(3'd0, 3'd2, 2'd0, 9'h040, 4'h3, 32'h00001234);
    rq[5] = mk(3'd4, 3'd2, 2'd1, 9'h040, 4'h0, 32'h0);
    rq[6] = mk(3'd4, 3'd2, 2'd2, 9'h024, 4'h0, 32'h0);
    rq[7] = mk(3'd4, 3'd2, 2'd3, 9'h004, 4'h0, 32'h0);
    @(posedge clock); #1;
    d_ready = 1'b0;
    drive_req(rq[0]);
    @(negedge clock);
    if (a_ready) sb.push_back(model(rq[0]));
    @(posedge clock); #1;
    idx = 1;
    drive_req(rq[1]);
    held = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      cur = observe();
      n_checks++;
      if (k == 0) begin
        held = cur;
        exp  = (sb.size() > 0) ? sb[0] : ~cur;
        if (d_valid !== 1'b1 || a_ready !== 1'b0 || cur !== exp) begin
          n_fails++; $display("FAIL stall[0]: v=%b rdy=%b got %h required v=1 rdy=0 %h", d_valid, a_ready, cur, exp);
        end
      end else if (d_valid !== 1'b1 || a_ready !== 1'b0 || cur !== held) begin
        n_fails++; $display("FAIL stall[%0d]: v=%b rdy=%b got %h required v=1 rdy=0 %h", k, d_valid, a_ready, cur, held);
      end
      @(posedge clock); #1;
    end
    d_ready = 1'b1;
    done = 0; cyc = 0;
    while (done < N && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (d_valid && d_ready) begin
        n_checks++;
        cur = observe();
        if (sb.size() == 0) begin
          n_fails++; $display("FAIL stream[%0d]: unexpected response %h", done, cur);
        end else begin
          exp = sb.pop_front();
          if (cur !== exp) begin
            n_fails++; $display("FAIL stream[%0d]: got %h required %h", done, cur, exp);
          end
        end
        done++;
      end
      fire = a_valid && a_ready;
      if (fire) sb.push_back(model(rq[idx]));
      @(posedge clock); #1;
      if (fire) begin
        idx++;
        if (idx < N) drive_req(rq[idx]); else drive_idle();
      end
    end
    n_checks++;
    if (done != N || cyc != N) begin
      n_fails++; $display("FAIL stream_rate: %0d responses in %0d cycles, required %0d in %0d", done, cyc, N, N);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    resp_t got, exp;
    bit    to, quiet;
    int    lat;
    xact(mk(3'd0, 3'd2, 2'd1, 9'h000, 4'hF, 32'h12345678), got, to, lat);
    xact(mk(3'd0, 3'd2, 2'd1, 9'h040, 4'hF, 32'h00005A5A), got, to, lat);
    sb.delete();
    @(posedge clock); #1;
    d_ready = 1'b0;
    drive_req(mk(3'd4, 3'd2, 2'd2, 9'h040, 4'h0, 32'h0));
    @(posedge clock); #1;
    drive_idle();
    @(negedge clock);
    n_checks++;
    if (d_valid !== 1'b1) begin
      n_fails++; $display("FAIL reset_mid_pending: d_valid=%b required 1", d_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (d_valid !== 1'b0 || a_ready !== 1'b1 || observe() !== '0) begin
      n_fails++; $display("FAIL reset_mid_async: v=%b rdy=%b d=%h, required 0 1 0", d_valid, a_ready, observe());
    end
    sb.delete();
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    d_ready = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (d_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fails++; $display("FAIL reset_mid_discard: d_valid seen 1 after reset, required 0");
    end
    for (int i = 0; i < 17; i++) begin
      xact(mk(3'd4, 3'd2, 2'd0, (i < 16) ? 9'(i * 4) : 9'h040, 4'h0, 32'h0), got, to, lat);
      n_checks++;
      if (to || sb.size() == 0) begin
        n_fails++; $display("FAIL reset_readback[%0d]: no response within bound", i); sb.delete();
      end else begin
        exp = sb.pop_front();
        if (got !== exp || got.data !== 32'h0) begin
          n_fails++; $display("FAIL reset_readback[%0d]: got %h required %h", i, got, exp);
        end
      end
    end
  endtask

  task automatic test_putcnt_wrap();
    req_t  r;
    resp_t got, exp, bad_got, bad_exp;
    bit    to;
    int    lat, fired, done, cyc, bad;
    r = mk(3'd0, 3'd2, 2'd2, 9'h040, 4'hF, 32'h0000ABCD);
    fired = 0; done = 0; cyc = 0; bad = 0;
    bad_got = '0; bad_exp = '0;
    @(posedge clock); #1;
    d_ready = 1'b1;
    drive_req(r);
    while (done < 65536 && cyc < 70000) begin
      @(negedge clock);
      cyc++;
      if (d_valid && d_ready) begin
        got = observe();
        exp = (sb.size() > 0) ? sb.pop_front() : ~got;
        if (got !== exp) begin
          if (bad == 0) begin bad_got = got; bad_exp = exp; end
          bad++;
        end
        done++;
      end
      if (a_valid && a_ready) begin
        sb.push_back(model(r));
        fired++;
      end
      @(posedge clock); #1;
      if (fired == 65536) drive_idle();
    end
    drive_idle();
    n_checks++;
    if (done != 65536 || bad != 0) begin
      n_fails++;
      $display("FAIL wrap_stream: %0d responses, %0d wrong (first got %h required %h), required 65536 and 0",
               done, bad, bad_got, bad_exp);
    end
    xact(mk(3'd4, 3'd2, 2'd1, 9'h040, 4'h0, 32'h0), got, to, lat);
    n_checks++;
    if (to || sb.size() == 0) begin
      n_fails++; $display("FAIL wrap_readback: no response within bound"); sb.delete();
    end else begin
      exp = sb.pop_front();
      if (got !== exp || got.data !== 32'h0000ABCD) begin
        n_fails++; $display("FAIL wrap_readback: got %h required %h data 0000ABCD", got, exp);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    d_ready = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_put_get();
    test_partial();
    test_denied();
    test_back_to_back();
    test_reset_mid();
    test_putcnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
